riscv_multicycle_ctrl: RTL and testbench

- Control FSM for the multicycle RV32I core variant. Sequences a single shared ALU, a unified instruction/data memory port and the register file across several cycles per instruction.
- Decodes the opcode held in the instruction register. Drives all datapath mux selects and write strobes.
- Waits on a memory ready handshake, with a bounded timeout.

---
 rtl/riscv_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU, unified memory port and register file.
// A bounded wait counter aborts stalled memory accesses back to FETCH with a one-cycle mem_err pulse.
module riscv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
        S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_JALR_ADR = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_R    = 7'b0110011, OP_I     = 7'b0010011,
                           OP_BEQ  = 7'b1100011, OP_JAL   = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_NOP   = 7'b0000000;

    state_t     r_state, w_next;
    logic [7:0] r_wait;
    logic       w_wait_st, w_timeout, w_pc_update;
    logic       w_mem_req, w_ir_write, w_reg_write, w_mem_write, w_illegal;

    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    // mem_ready on the limit cycle wins, so the abort only fires while still stalled
    assign w_timeout = w_wait_st && !mem_ready && (r_wait == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_update = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        result_src  = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BEQ:            w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR_ADR;
                    OP_NOP:            w_next = S_FETCH;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_LOAD)       w_next = S_MEMREAD;
                else if (op == OP_STORE) w_next = S_MEMWRITE;
                else                     w_next = S_FETCH;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = S_JAL;
            end
            default: w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_FETCH;
    end

    always_comb begin
        case (op)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_timeout || (w_next != r_state)) r_wait <= 8'd0;
            else if (w_wait_st && !mem_ready)     r_wait <= r_wait + 8'd1;
        end
    end

    // Strobes are gated by rst so nothing is issued while reset is held
    assign mem_req    = w_mem_req & ~rst;
    assign ir_write   = w_ir_write & ~rst;
    assign pc_write   = (w_pc_update | (branch & zero)) & ~rst;
    assign reg_write  = w_reg_write & ~rst;
    assign mem_write  = w_mem_write & ~rst;
    assign illegal_op = w_illegal & ~rst;
    assign mem_err    = w_timeout & ~rst;
    assign state_o    = r_state;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: state sequences, strobes, wait handshake, timeout and reset.
// Inputs change just after the falling edge; outputs are checked 1ns later, away from the rising edge.
module tb_riscv_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, adr_src, ir_write, pc_write, reg_write, mem_write, branch;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic       illegal_op, mem_err;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem_write(mem_write), .branch(branch),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .illegal_op(illegal_op),
        .mem_err(mem_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Leaves the bench just after a falling edge with the DUT in FETCH and rst low
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        op = 7'b0110011;
        #1;
        checks++;
        if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++;
        if ({mem_req, ir_write, pc_write, reg_write, mem_write, illegal_op, mem_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 0000000",
                     {mem_req, ir_write, pc_write, reg_write, mem_write, illegal_op, mem_err});
        end
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || ir_write !== 1'b0 || alu_src_b !== 2'b10 || result_src !== 2'b10) begin
            errors++;
            $display("FAIL reset_fetch got req=%b irw=%b srcb=%b res=%b want 1 0 10 10",
                     mem_req, ir_write, alu_src_b, result_src);
        end
    endtask

    task automatic test_rtype();
        int exp_st[5] = '{0, 1, 6, 8, 0};
        int nwr = 0;
        for (int i = 0; i < 5; i++) begin
            op = 7'b0110011;
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i])) begin
                errors++; $display("FAIL rtype_state cyc %0d got %0d want %0d", i, state_o, exp_st[i]);
            end
            checks++;
            if (ir_write !== (exp_st[i] == 0) || pc_write !== (exp_st[i] == 0)) begin
                errors++; $display("FAIL rtype_irpc cyc %0d got %b%b want %0d", i, ir_write, pc_write, exp_st[i] == 0);
            end
            if (reg_write === 1'b1) nwr++;
            if (exp_st[i] == 6) begin
                checks++;
                if (alu_src_a !== 2'b10 || alu_src_b !== 2'b00 || alu_op !== 2'b10) begin
                    errors++; $display("FAIL rtype_exec got a=%b b=%b op=%b want 10 00 10", alu_src_a, alu_src_b, alu_op);
                end
            end
            if (i < 4) @(negedge clk);
        end
        checks++;
        if (nwr != 1) begin errors++; $display("FAIL rtype_regwrite_count got %0d want 1", nwr); end
    endtask

    task automatic test_lw_wait();
        int exp_st[9]   = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic exp_mr[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        int nreq = 0;
        for (int i = 0; i < 9; i++) begin
            op = 7'b0000011;
            mem_ready = exp_mr[i];
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i]) || mem_err !== 1'b0) begin
                errors++; $display("FAIL lw_state cyc %0d got %0d err=%b want %0d err=0", i, state_o, mem_err, exp_st[i]);
            end
            if (exp_st[i] == 3) begin
                if (mem_req === 1'b1 && adr_src === 1'b1) nreq++;
            end
            if (exp_st[i] == 4) begin
                checks++;
                if (result_src !== 2'b01 || reg_write !== 1'b1) begin
                    errors++; $display("FAIL lw_memwb got res=%b wr=%b want 01 1", result_src, reg_write);
                end
            end
            if (i < 8) @(negedge clk);
        end
        checks++;
        if (nreq != 4) begin errors++; $display("FAIL lw_req_cycles got %0d want 4", nreq); end
    endtask

    task automatic test_beq();
        int exp_st[4] = '{0, 1, 9, 0};
        for (int z = 1; z >= 0; z--) begin
            for (int i = 0; i < 4; i++) begin
                op = 7'b1100011;
                zero = 1'(z);
                mem_ready = 1'b1;
                #1;
                checks++;
                if (state_o !== 4'(exp_st[i]) || imm_src !== 2'b10) begin
                    errors++; $display("FAIL beq_state z=%0d cyc %0d got %0d imm=%b want %0d 10", z, i, state_o, imm_src, exp_st[i]);
                end
                if (exp_st[i] == 9) begin
                    checks++;
                    if (pc_write !== 1'(z) || branch !== 1'b1 || alu_op !== 2'b01) begin
                        errors++; $display("FAIL beq_pcwrite z=%0d got pcw=%b br=%b aop=%b want %0d 1 01", z, pc_write, branch, alu_op, z);
                    end
                end
                if (i < 3) @(negedge clk);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jalr();
        int exp_st[6] = '{0, 1, 11, 10, 8, 0};
        for (int i = 0; i < 6; i++) begin
            op = 7'b1100111;
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i])) begin
                errors++; $display("FAIL jalr_state cyc %0d got %0d want %0d", i, state_o, exp_st[i]);
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (pc_write !== (exp_st[i] == 10) || reg_write !== (exp_st[i] == 8)) begin
                    errors++; $display("FAIL jalr_strobes cyc %0d got pcw=%b wr=%b", i, pc_write, reg_write);
                end
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_illegal_nop();
        logic [6:0] ops[2] = '{7'b1111111, 7'b0000000};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                op = ops[k];
                mem_ready = 1'b1;
                #1;
                checks++;
                if (state_o !== ((i == 1) ? 4'd1 : 4'd0) || illegal_op !== (i == 1 && k == 0)) begin
                    errors++; $display("FAIL illegal_nop op=%b cyc %0d got st=%0d ill=%b", ops[k], i, state_o, illegal_op);
                end
                if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
                    errors++; $display("FAIL illegal_nop_strobe op=%b cyc %0d got wr=%b mw=%b want 0 0", ops[k], i, reg_write, mem_write);
                end
                if (i < 2) @(negedge clk);
            end
        end
    endtask

    task automatic test_sw_timeout();
        int exp_st[3] = '{0, 1, 2};
        for (int i = 0; i < 3; i++) begin
            op = 7'b0100011;
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i]) || imm_src !== 2'b01) begin
                errors++; $display("FAIL sw_state cyc %0d got %0d imm=%b want %0d 01", i, state_o, imm_src, exp_st[i]);
            end
            @(negedge clk);
        end
        for (int w = 1; w <= 15; w++) begin
            mem_ready = 1'b0;
            #1;
            checks++;
            if (state_o !== 4'd5 || mem_err !== (w == 15)) begin
                errors++; $display("FAIL sw_wait cyc %0d got st=%0d err=%b want 5 %0d", w, state_o, mem_err, w == 15);
            end
            if (w < 15) begin
                checks++;
                if (mem_write !== 1'b1 || mem_req !== 1'b1) begin
                    errors++; $display("FAIL sw_hold cyc %0d got mw=%b req=%b want 1 1", w, mem_write, mem_req);
                end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state_o !== 4'd0 || mem_write !== 1'b0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL sw_abort got st=%0d mw=%b err=%b want 0 0 0", state_o, mem_write, mem_err);
        end
    endtask

    task automatic test_reset_mid();
        int exp_st[5] = '{0, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            op = 7'b0000011;
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i])) begin
                errors++; $display("FAIL rstmid_state cyc %0d got %0d want %0d", i, state_o, exp_st[i]);
            end
            if (i < 4) @(negedge clk);
        end
        checks++;
        if (reg_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre got wr=%b want 1", reg_write); end
        rst = 1'b1;
        #1;
        checks++;
        if (reg_write !== 1'b0 || state_o !== 4'd0) begin
            errors++; $display("FAIL rstmid_abort got wr=%b st=%0d want 0 0", reg_write, state_o);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_jalr();
        test_illegal_nop();
        test_sw_timeout();
        do_reset();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
